greenflow_power_scheduler: RTL and testbench
============================================

GREENFLOW_POWER_SCHEDULER -- requirements
Module: greenflow_power_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to run one allocation round; sampled only in IDLE.
REQ-005 grid_budget_kw  in  16  total site power budget (kW, unsigned) for the round.
REQ-006 req_valid  in  4  per-port charger demand present.
REQ-007 req_kw  in  64  four packed 16-bit demands; port p uses bits [16p+15:16p].
REQ-008 port_fault  in  4  per-port fault (AI lost or thermal lockout); a faulted port is granted 0.
REQ-009 alloc_kw  out  64  four packed 16-bit grants in the same packing as req_kw; registered.
REQ-010 alloc_valid  out  1  one-cycle pulse when alloc_kw, clip_mask and budget_left are updated.
REQ-011 clip_mask  out  4  bit p set when port p is valid, not faulted, and granted less than its demand.
REQ-012 budget_left  out  16  unallocated budget remaining after the round.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 rr_ptr  out  2  port served first in the next round.

Function
REQ-015 The FSM SHALL have the states IDLE, LATCH, ALLOC and DONE.
REQ-016 IDLE -> LATCH when start=1; start SHALL be ignored in every state other than IDLE.
REQ-017 LATCH SHALL capture grid_budget_kw, req_valid, req_kw and port_fault into internal registers.
REQ-018 Input changes after LATCH SHALL NOT affect the round.
REQ-019 ALLOC SHALL last exactly 4 cycles and SHALL serve one port per cycle in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-020 Per served port, the grant SHALL be 0 if the latched req_valid=0 or port_fault=1.
REQ-021 Otherwise the grant SHALL be min(req, remaining), and remaining SHALL then be decremented by the grant.
REQ-022 remaining SHALL start at the latched budget.
REQ-023 Arithmetic SHALL be unsigned 16-bit, and remaining SHALL never underflow (grant <= remaining).
REQ-024 DONE SHALL last one cycle: it updates alloc_kw, clip_mask and budget_left, pulses alloc_valid, sets rr_ptr <= rr_ptr+1 (wraps 3 -> 0), and returns to IDLE.
REQ-025 Latency: start sampled on edge k SHALL cause alloc_valid=1 in the cycle following edge k+6, with the outputs updated on that same edge.
REQ-026 alloc_kw, clip_mask and budget_left SHALL hold their values between DONE pulses.
REQ-027 Budget 0: all grants SHALL be 0, and clip_mask SHALL be set for every valid, non-faulted port with a nonzero demand.
REQ-028 A demand of 0 on a valid port SHALL grant 0 and SHALL NOT set clip.
REQ-029 start held high continuously SHALL run back-to-back rounds, each one re-entering LATCH from IDLE.

Reset
REQ-030 rst=1 SHALL force: state IDLE, alloc_kw=0, clip_mask=0, budget_left=0, alloc_valid=0, busy=0, rr_ptr=0, and all internal latches to 0.
REQ-031 A reset asserted mid-round SHALL abort the round with no alloc_valid pulse.
REQ-032 The first round after reset release SHALL start at port 0.

Configuration
REQ-033 Macro GREENFLOW_FAIR_CAP_EN, when defined: each grant SHALL be min(req, remaining, latched_budget >> 2), so no port receives more than a quarter share per round.
REQ-034 When GREENFLOW_FAIR_CAP_EN is undefined: grants SHALL be greedy, min(req, remaining), and no cap logic SHALL be synthesized.
REQ-035 clip_mask SHALL reflect the applied limit in both configurations.

Verification
REQ-036 Greedy allocation: budget 200, all ports valid, req 50/60/70/80, rr_ptr=0, no faults -> alloc 50/60/70/20, clip_mask=4'b1000, budget_left=0, rr_ptr becomes 1.
REQ-037 Round-robin rotation: repeat REQ-036 stimulus with rr_ptr=1 -> order 1,2,3,0; alloc port0..3 = 0/60/70/70, clip_mask=4'b1001, budget_left=0.
REQ-038 Fault exclusion: budget 200, req 50/60/70/80, port_fault=4'b0100, rr_ptr=0 -> alloc 50/60/0/80, clip_mask=0, budget_left=10.
REQ-039 Start while busy and reset mid-round: start asserted during ALLOC is ignored (single alloc_valid pulse); rst asserted during ALLOC -> no pulse, all outputs 0, rr_ptr=0.
REQ-040 GREENFLOW_FAIR_CAP_EN defined: budget 200, req 100/10/100/100, rr_ptr=0 -> alloc 50/10/50/50, clip_mask=4'b1101, budget_left=40.
REQ-041 Latency and hold: alloc_valid high exactly one cycle, in the cycle following the 6th rising edge after the start-sampling edge; outputs stable until the next DONE.

Source files
------------

// File: rtl/greenflow_power_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// greenflow_power_scheduler
//
// Splits a site power budget across four EV charger ports, one allocation
// round per start request. The round latches its inputs and then serves one
// port per cycle in round-robin order, beginning at rr_ptr. Each served,
// non-faulted port with a pending demand is granted min(demand, remaining).
// The results are published together with a one-cycle alloc_valid_o pulse.
//
// Optional feature: define GREENFLOW_FAIR_CAP_EN to also cap every grant at
// a quarter of the latched budget.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   start_i          round request, only sampled in IDLE
//   grid_budget_kw_i total budget for the round (kW)
//   req_valid_i      per-port demand present
//   req_kw_i         4 x 16-bit demands, port p at [16p+15:16p]
//   port_fault_i     per-port fault, forces a zero grant
//   alloc_kw_o       4 x 16-bit grants, same packing as req_kw_i
//   alloc_valid_o    one-cycle pulse when the results update
//   clip_mask_o      port valid, not faulted, and granted less than demand
//   budget_left_o    budget left unallocated after the round
//   busy_o           high whenever the FSM is not in IDLE
//   rr_ptr_o         port served first in the next round
// -----------------------------------------------------------------------------
module greenflow_power_scheduler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] grid_budget_kw_i,
  input  logic [3:0]  req_valid_i,
  input  logic [63:0] req_kw_i,
  input  logic [3:0]  port_fault_i,
  output logic [63:0] alloc_kw_o,
  output logic        alloc_valid_o,
  output logic [3:0]  clip_mask_o,
  output logic [15:0] budget_left_o,
  output logic        busy_o,
  output logic [1:0]  rr_ptr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ALLOC = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  fault_q, fault_d;
  logic [63:0] req_q, req_d;
  logic [15:0] remaining_q, remaining_d;
  logic [63:0] grant_q, grant_d;
  logic [3:0]  clip_q, clip_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [63:0] alloc_kw_q, alloc_kw_d;
  logic        alloc_valid_q, alloc_valid_d;
  logic [3:0]  clip_mask_q, clip_mask_d;
  logic [15:0] budget_left_q, budget_left_d;
`ifdef GREENFLOW_FAIR_CAP_EN
  logic [15:0] cap_q, cap_d;
`endif

  logic [1:0]  port_s;
  logic [15:0] req_s;
  logic        eligible_s;
  logic [15:0] limit_s;
  logic [15:0] grant_s;

  // Grant for the port served this ALLOC cycle; limit never exceeds
  // remaining, so the subtraction cannot underflow.
  always_comb begin
    port_s     = rr_ptr_q + cnt_q;
    req_s      = req_q[{port_s, 4'b0000} +: 16];
    eligible_s = valid_q[port_s] & ~fault_q[port_s];
`ifdef GREENFLOW_FAIR_CAP_EN
    if (cap_q < remaining_q) begin
      limit_s = cap_q;
    end else begin
      limit_s = remaining_q;
    end
`else
    limit_s = remaining_q;
`endif
    if (!eligible_s) begin
      grant_s = 16'd0;
    end else if (req_s < limit_s) begin
      grant_s = req_s;
    end else begin
      grant_s = limit_s;
    end
  end

  // Next-state and datapath updates for the allocation FSM.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    fault_d       = fault_q;
    req_d         = req_q;
    remaining_d   = remaining_q;
    grant_d       = grant_q;
    clip_d        = clip_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    alloc_kw_d    = alloc_kw_q;
    alloc_valid_d = 1'b0;
    clip_mask_d   = clip_mask_q;
    budget_left_d = budget_left_q;
`ifdef GREENFLOW_FAIR_CAP_EN
    cap_d         = cap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        valid_d     = req_valid_i;
        fault_d     = port_fault_i;
        req_d       = req_kw_i;
        remaining_d = grid_budget_kw_i;
        grant_d     = 64'd0;
        clip_d      = 4'd0;
        cnt_d       = 2'd0;
`ifdef GREENFLOW_FAIR_CAP_EN
        cap_d       = {2'b00, grid_budget_kw_i[15:2]};
`endif
        state_d     = ALLOC;
      end
      ALLOC: begin
        grant_d[{port_s, 4'b0000} +: 16] = grant_s;
        clip_d[port_s] = eligible_s & (grant_s < req_s);
        remaining_d    = remaining_q - grant_s;
        cnt_d          = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = ALLOC;
        end
      end
      DONE: begin
        alloc_kw_d    = grant_q;
        clip_mask_d   = clip_q;
        budget_left_d = remaining_q;
        alloc_valid_d = 1'b1;
        rr_ptr_d      = rr_ptr_q + 2'd1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any round in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      valid_q       <= 4'd0;
      fault_q       <= 4'd0;
      req_q         <= 64'd0;
      remaining_q   <= 16'd0;
      grant_q       <= 64'd0;
      clip_q        <= 4'd0;
      cnt_q         <= 2'd0;
      rr_ptr_q      <= 2'd0;
      alloc_kw_q    <= 64'd0;
      alloc_valid_q <= 1'b0;
      clip_mask_q   <= 4'd0;
      budget_left_q <= 16'd0;
`ifdef GREENFLOW_FAIR_CAP_EN
      cap_q         <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
      req_q         <= req_d;
      remaining_q   <= remaining_d;
      grant_q       <= grant_d;
      clip_q        <= clip_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      alloc_kw_q    <= alloc_kw_d;
      alloc_valid_q <= alloc_valid_d;
      clip_mask_q   <= clip_mask_d;
      budget_left_q <= budget_left_d;
`ifdef GREENFLOW_FAIR_CAP_EN
      cap_q         <= cap_d;
`endif
    end
  end

  assign alloc_kw_o    = alloc_kw_q;
  assign alloc_valid_o = alloc_valid_q;
  assign clip_mask_o   = clip_mask_q;
  assign budget_left_o = budget_left_q;
  assign busy_o        = (state_q != IDLE);
  assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_greenflow_power_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for greenflow_power_scheduler: directed scenarios plus
// randomized rounds compared against a behavioural allocation model.
module tb_greenflow_power_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] grid;
  logic [3:0]  rv;
  logic [63:0] rk;
  logic [3:0]  pf;
  logic [63:0] alloc_kw;
  logic        alloc_valid;
  logic [3:0]  clip_mask;
  logic [15:0] budget_left;
  logic        busy;
  logic [1:0]  rr_ptr;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  rr_exp  = 2'd0;

  greenflow_power_scheduler dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .grid_budget_kw_i (grid),
    .req_valid_i      (rv),
    .req_kw_i         (rk),
    .port_fault_i     (pf),
    .alloc_kw_o       (alloc_kw),
    .alloc_valid_o    (alloc_valid),
    .clip_mask_o      (clip_mask),
    .budget_left_o    (budget_left),
    .busy_o           (busy),
    .rr_ptr_o         (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Allocation rules written as a plain loop over ports in service order.
  function automatic void model(input logic [15:0] b, input logic [3:0] v, input logic [63:0] r,
                                input logic [3:0] f, input logic [1:0] rr,
                                output logic [63:0] alloc, output logic [3:0] clip,
                                output logic [15:0] left);
    int rem, lim, d, g, p;
    rem   = int'(b);
    alloc = '0;
    clip  = '0;
    for (int i = 0; i < 4; i++) begin
      p   = (int'(rr) + i) % 4;
      d   = int'(r[p*16 +: 16]);
      g   = 0;
      lim = rem;
`ifdef GREENFLOW_FAIR_CAP_EN
      if (int'(b) / 4 < lim) lim = int'(b) / 4;
`endif
      if (v[p] && !f[p]) begin
        g       = (d < lim) ? d : lim;
        clip[p] = (g < d);
      end
      rem = rem - g;
      alloc[p*16 +: 16] = 16'(g);
    end
    left = 16'(rem);
  endfunction

  task automatic scramble_inputs();
    grid = 16'($urandom);
    rv   = 4'($urandom);
    rk   = {$urandom, $urandom};
    pf   = 4'($urandom);
  endtask

  task automatic run_round(input logic [15:0] b, input logic [3:0] v, input logic [63:0] r,
                           input logic [3:0] f, input bit mid_start);
    logic [63:0] e_alloc;
    logic [3:0]  e_clip;
    logic [15:0] e_left;
    int          lat;
    model(b, v, r, f, rr_exp, e_alloc, e_clip, e_left);
    @(negedge clk);
    check_eq("rr_before", 64'(rr_ptr), 64'(rr_exp));
    grid = b; rv = v; rk = r; pf = f; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_in_round", 64'(busy), 64'(1'b1));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    scramble_inputs();
    start = mid_start;
    while (alloc_valid !== 1'b1 && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("latency", 64'(lat), 64'(6));
    check_eq("alloc_kw", alloc_kw, e_alloc);
    check_eq("clip_mask", 64'(clip_mask), 64'(e_clip));
    check_eq("budget_left", 64'(budget_left), 64'(e_left));
    check_eq("busy_at_pulse", 64'(busy), 64'(1'b0));
    rr_exp = 2'(rr_exp + 2'd1);
    check_eq("rr_after", 64'(rr_ptr), 64'(rr_exp));
    @(posedge clk);
    @(negedge clk);
    check_eq("pulse_width", 64'(alloc_valid), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("hold_alloc", alloc_kw, e_alloc);
    check_eq("hold_clip", 64'(clip_mask), 64'(e_clip));
    check_eq("hold_left", 64'(budget_left), 64'(e_left));
    check_eq("no_extra_round", 64'({busy, alloc_valid}), 64'(2'b00));
  endtask

  task automatic reset_mid_round();
    int pulses;
    pulses = 0;
    @(negedge clk);
    grid = 16'd300; rv = 4'hF; rk = {$urandom, $urandom}; pf = 4'h0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_alloc", alloc_kw, 64'd0);
    check_eq("rst_clip", 64'(clip_mask), 64'(4'd0));
    check_eq("rst_left", 64'(budget_left), 64'(16'd0));
    check_eq("rst_rr", 64'(rr_ptr), 64'(2'd0));
    check_eq("rst_busy", 64'(busy), 64'(1'b0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (alloc_valid === 1'b1) pulses++;
    end
    check_eq("rst_no_pulse", 64'(pulses), 64'(0));
    rr_exp = 2'd0;
  endtask

  task automatic back_to_back(input logic [15:0] b, input logic [3:0] v, input logic [63:0] r,
                              input logic [3:0] f);
    logic [63:0] a1, a2;
    logic [3:0]  c1, c2;
    logic [15:0] l1, l2;
    int          lat;
    model(b, v, r, f, rr_exp, a1, c1, l1);
    model(b, v, r, f, 2'(rr_exp + 2'd1), a2, c2, l2);
    @(negedge clk);
    grid = b; rv = v; rk = r; pf = f; start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (alloc_valid !== 1'b1 && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("b2b_lat1", 64'(lat), 64'(6));
    check_eq("b2b_alloc1", alloc_kw, a1);
    check_eq("b2b_clip1", 64'(clip_mask), 64'(c1));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (alloc_valid !== 1'b1 && lat < 14) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("b2b_lat2", 64'(lat), 64'(7));
    check_eq("b2b_alloc2", alloc_kw, a2);
    check_eq("b2b_clip2", 64'(clip_mask), 64'(c2));
    check_eq("b2b_left2", 64'(budget_left), 64'(l2));
    rr_exp = 2'(rr_exp + 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("b2b_stop", 64'(busy), 64'(1'b0));
    check_eq("b2b_rr", 64'(rr_ptr), 64'(rr_exp));
  endtask

  initial begin
    logic [15:0] b;
    logic [63:0] r;
    rst = 1'b1; start = 1'b0; grid = 16'd0; rv = 4'd0; rk = 64'd0; pf = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_alloc", alloc_kw, 64'd0);
    check_eq("reset_outs", 64'({alloc_valid, busy, clip_mask, rr_ptr}), 64'(8'd0));
    check_eq("reset_left", 64'(budget_left), 64'(16'd0));
    rst = 1'b0;

    // Greedy reference stimulus from rr_ptr 0, then rotated from rr_ptr 1.
    run_round(16'd200, 4'hF, {16'd80, 16'd70, 16'd60, 16'd50}, 4'h0, 1'b0);
`ifndef GREENFLOW_FAIR_CAP_EN
    check_eq("greedy_alloc", alloc_kw, {16'd20, 16'd70, 16'd60, 16'd50});
    check_eq("greedy_clip", 64'(clip_mask), 64'(4'b1000));
`endif
    run_round(16'd200, 4'hF, {16'd80, 16'd70, 16'd60, 16'd50}, 4'h0, 1'b0);
`ifndef GREENFLOW_FAIR_CAP_EN
    check_eq("rotate_alloc", alloc_kw, {16'd70, 16'd70, 16'd60, 16'd0});
    check_eq("rotate_clip", 64'(clip_mask), 64'(4'b1001));
`endif
    // Start held during ALLOC must not launch another round.
    run_round(16'd120, 4'hB, {16'd30, 16'd90, 16'd0, 16'd45}, 4'h0, 1'b1);
    run_round(16'd0, 4'hF, {16'd10, 16'd0, 16'd5, 16'd7}, 4'h2, 1'b0);
    run_round(16'd200, 4'hF, {16'd80, 16'd70, 16'd60, 16'd50}, 4'b0100, 1'b0);
`ifndef GREENFLOW_FAIR_CAP_EN
    check_eq("fault_alloc", alloc_kw, {16'd80, 16'd0, 16'd60, 16'd50});
    check_eq("fault_left", 64'(budget_left), 64'(16'd10));
`endif
    reset_mid_round();
    run_round(16'd200, 4'hF, {16'd100, 16'd100, 16'd10, 16'd100}, 4'h0, 1'b0);
`ifdef GREENFLOW_FAIR_CAP_EN
    check_eq("fair_alloc", alloc_kw, {16'd50, 16'd50, 16'd10, 16'd50});
    check_eq("fair_clip", 64'(clip_mask), 64'(4'b1101));
    check_eq("fair_left", 64'(budget_left), 64'(16'd40));
`endif
    back_to_back(16'd150, 4'hF, {16'd60, 16'd60, 16'd60, 16'd60}, 4'h0);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 100));
        2:       b = 16'($urandom_range(100, 600));
        default: b = 16'($urandom);
      endcase
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 4) == 0) r[p*16 +: 16] = 16'd0;
        else if ($urandom_range(0, 5) == 0) r[p*16 +: 16] = 16'($urandom);
        else r[p*16 +: 16] = 16'($urandom_range(1, 300));
      end
      run_round(b, 4'($urandom), r, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
